// File: rtl/mem_wb_stage.sv
// ----------------------------------------------------------------------------
// mem_wb_stage
//   MEM/WB pipeline register followed by the writeback stage. It captures the
//   memory stage's async read data, ALU result, destination register and
//   control on each rising edge. It then extracts byte/halfword loads,
//   applies sign or zero extension, and selects the ALU result or the load
//   value. It drives the register-file write port, which is also the WB
//   forwarding source.
//
//   Optional feature macro: RETIRE_CNT_EN
//     defined   : CNT_W-bit retired-instruction counter on retired_count_out
//     undefined : no counter logic; retired_count_out tied to 0
//
// Parameters
//   DATA_W  datapath width (only 32 supported)
//   REG_AW  register address width
//   CNT_W   retire counter width
//
// Ports
//   clk                 in   rising-edge clock
//   reset               in   synchronous active-high reset
//   valid_in            in   MEM stage holds a real instruction
//   read_data_in        in   word read from data memory
//   alu_result_in       in   ALU result / byte address
//   write_register_in   in   destination register
//   reg_write_in        in   register write enable
//   mem_to_reg_in       in   1 = load data, 0 = ALU result
//   load_size_in        in   00 word, 01 half, 10 byte, 11 word
//   load_unsigned_in    in   1 = zero-extend, 0 = sign-extend
//   stall               in   hold MEM/WB contents
//   flush               in   replace captured entry with a bubble
//   write_data_out      out  register file write data
//   write_register_out  out  register file write address
//   reg_write_out       out  qualified register file write enable
//   retired_count_out   out  retired instruction count
// ----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [REG_AW-1:0] write_register_in,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic [1:0]        load_size_in,
  input  logic              load_unsigned_in,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] write_data_out,
  output logic [REG_AW-1:0] write_register_out,
  output logic              reg_write_out,
  output logic [CNT_W-1:0]  retired_count_out
);

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  // Little-endian lane extraction plus extension. Halfword offset uses only
  // addr[1]; misaligned halfwords are silently realigned, never trapped.
  function automatic logic [DATA_W-1:0] load_extract(
    input logic [DATA_W-1:0] rd,
    input logic [1:0]        addr,
    input logic [1:0]        size,
    input logic              uns
  );
    logic signed [15:0] half;
    logic signed [7:0]  byte_v;
    logic [DATA_W-1:0]  res;
    half   = addr[1] ? rd[31:16] : rd[15:0];
    byte_v = rd[8*addr +: 8];
    case (size)
      SZ_HALF: res = uns ? {16'd0, half}  : DATA_W'(half);
      SZ_BYTE: res = uns ? {24'd0, byte_v} : DATA_W'(byte_v);
      default: res = rd;
    endcase
    return res;
  endfunction

  logic              valid_q,     valid_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic [DATA_W-1:0] alu_q,       alu_d;
  logic [REG_AW-1:0] wr_reg_q,    wr_reg_d;
  logic              reg_write_q, reg_write_d;
  logic              m2r_q,       m2r_d;
  logic [1:0]        size_q,      size_d;
  logic              uns_q,       uns_d;

  // A capture is a normal load of the stage (not held, not flushed).
  logic capture;
  assign capture = !flush && !stall;

  always_comb begin
    valid_d     = valid_q;
    read_data_d = read_data_q;
    alu_d       = alu_q;
    wr_reg_d    = wr_reg_q;
    reg_write_d = reg_write_q;
    m2r_d       = m2r_q;
    size_d      = size_q;
    uns_d       = uns_q;
    if (flush) begin
      // Flush outranks stall; only the qualifying bits need clearing.
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (!stall) begin
      valid_d     = valid_in;
      read_data_d = read_data_in;
      alu_d       = alu_result_in;
      wr_reg_d    = write_register_in;
      reg_write_d = reg_write_in;
      m2r_d       = mem_to_reg_in;
      size_d      = load_size_in;
      uns_d       = load_unsigned_in;
    end
  end

  // ---- MEM -> WB register boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      read_data_q <= '0;
      alu_q       <= '0;
      wr_reg_q    <= '0;
      reg_write_q <= 1'b0;
      m2r_q       <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      read_data_q <= read_data_d;
      alu_q       <= alu_d;
      wr_reg_q    <= wr_reg_d;
      reg_write_q <= reg_write_d;
      m2r_q       <= m2r_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
    end
  end

  // ---- WB stage: outputs depend only on registered state ----
  assign write_register_out = wr_reg_q;
  assign reg_write_out      = valid_q && reg_write_q && (wr_reg_q != '0);
  assign write_data_out     = m2r_q ? load_extract(read_data_q, alu_q[1:0], size_q, uns_q)
                                    : alu_q;

`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Natural binary wrap from all-ones back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (capture && valid_in) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign retired_count_out = cnt_q;
`else
  logic unused_capture;
  assign unused_capture    = capture;
  assign retired_count_out = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] read_data_in = '0;
  logic [31:0] alu_result_in = '0;
  logic [4:0]  write_register_in = '0;
  logic        reg_write_in = 1'b0;
  logic        mem_to_reg_in = 1'b0;
  logic [1:0]  load_size_in = 2'b00;
  logic        load_unsigned_in = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] write_data_out;
  logic [4:0]  write_register_out;
  logic        reg_write_out;
  logic [CW-1:0] retired_count_out;

  mem_wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .read_data_in(read_data_in), .alu_result_in(alu_result_in),
    .write_register_in(write_register_in), .reg_write_in(reg_write_in),
    .mem_to_reg_in(mem_to_reg_in), .load_size_in(load_size_in),
    .load_unsigned_in(load_unsigned_in), .stall(stall), .flush(flush),
    .write_data_out(write_data_out), .write_register_out(write_register_out),
    .reg_write_out(reg_write_out), .retired_count_out(retired_count_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the instruction currently sitting in writeback.
  logic        m_valid, m_rw, m_m2r, m_uns;
  logic [4:0]  m_reg;
  logic [1:0]  m_size;
  logic [31:0] m_rd, m_alu;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_data();
    logic [31:0] v;
    int sh;
    if (!m_m2r) return m_alu;
    if (m_size == 2'd1) begin
      sh = m_alu[1] ? 16 : 0;
      v = (m_rd >> sh) & 32'h0000_FFFF;
      if (!m_uns && v >= 32'h0000_8000) v = v | 32'hFFFF_0000;
    end else if (m_size == 2'd2) begin
      sh = 8 * int'(m_alu[1:0]);
      v = (m_rd >> sh) & 32'h0000_00FF;
      if (!m_uns && v >= 32'h0000_0080) v = v | 32'hFFFF_FF00;
    end else begin
      v = m_rd;
    end
    return v;
  endfunction

  task automatic check_outputs();
    chk("reg_write", {31'd0, reg_write_out}, {31'd0, (m_valid && m_rw && m_reg != 5'd0)});
    if (m_valid) begin
      chk("wr_reg", {27'd0, write_register_out}, {27'd0, m_reg});
      chk("wr_data", write_data_out, model_data());
    end
`ifdef RETIRE_CNT_EN
    chk("count", 32'(retired_count_out), 32'(m_cnt));
`else
    chk("count_tied", 32'(retired_count_out), 32'd0);
`endif
  endtask

  // One clock: advance model with the inputs seen at the edge, then check.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_rw = 0; m_m2r = 0; m_uns = 0;
      m_reg = '0; m_size = '0; m_rd = '0; m_alu = '0; m_cnt = 0;
    end else if (flush) begin
      m_valid = 0; m_rw = 0;
    end else if (!stall) begin
      m_valid = valid_in; m_rw = reg_write_in; m_m2r = mem_to_reg_in;
      m_uns = load_unsigned_in; m_reg = write_register_in; m_size = load_size_in;
      m_rd = read_data_in; m_alu = alu_result_in;
      if (valid_in) m_cnt = (m_cnt + 1) % (1 << CW);
    end
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [31:0] rd, input logic [31:0] alu,
                       input logic [4:0] wr, input logic rw, input logic m2r,
                       input logic [1:0] sz, input logic uns,
                       input logic st, input logic fl);
    valid_in = v; read_data_in = rd; alu_result_in = alu; write_register_in = wr;
    reg_write_in = rw; mem_to_reg_in = m2r; load_size_in = sz; load_unsigned_in = uns;
    stall = st; flush = fl;
  endtask

  task automatic load_case(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] exp);
    drive(1, 32'hCAFE_80F1, addr, 5'd9, 1, 1, sz, uns, 0, 0);
    tick();
    chk(tag, write_data_out, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, '0, '0, '0, 0, 0, 2'b00, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset and release
    do_reset();
    chk("rst_data", write_data_out, 32'd0);
    chk("rst_reg", {27'd0, write_register_out}, 32'd0);
    chk("rst_rw", {31'd0, reg_write_out}, 32'd0);
    chk("rst_cnt", 32'(retired_count_out), 32'd0);
    tick();
    chk("post_rst_rw", {31'd0, reg_write_out}, 32'd0);

    // ALU writeback
    drive(1, 32'h0, 32'h0000_1234, 5'd5, 1, 0, 2'b00, 0, 0, 0);
    tick();
    chk("alu_data", write_data_out, 32'h0000_1234);
    chk("alu_reg", {27'd0, write_register_out}, 32'd5);
    chk("alu_rw", {31'd0, reg_write_out}, 32'd1);

    // Loads from 0xCAFE_80F1
    load_case("lb_a0_s",  2'b10, 0, 32'h0000_1000, 32'hFFFF_FFF1);
    load_case("lbu_a0",   2'b10, 1, 32'h0000_1000, 32'h0000_00F1);
    load_case("lh_a2_s",  2'b01, 0, 32'h0000_1002, 32'hFFFF_CAFE);
    load_case("lhu_a0",   2'b01, 1, 32'h0000_1000, 32'h0000_80F1);
    load_case("lw",       2'b00, 0, 32'h0000_1000, 32'hCAFE_80F1);
    load_case("lb_a1_s",  2'b10, 0, 32'h0000_1001, 32'hFFFF_FF80);
    load_case("lbu_a3",   2'b10, 1, 32'h0000_1003, 32'h0000_00CA);
    load_case("lh_a3_mis",2'b01, 0, 32'h0000_1003, 32'hFFFF_CAFE);
    load_case("lrsv_word",2'b11, 0, 32'h0000_1001, 32'hCAFE_80F1);

    // Write to $0 suppressed
    drive(1, 32'h0, 32'hDEAD_BEEF, 5'd0, 1, 0, 2'b00, 0, 0, 0);
    tick();
    chk("x0_rw", {31'd0, reg_write_out}, 32'd0);

    // Stall holds entry A, then stall+flush produces a bubble
    drive(1, 32'h0, 32'h0000_0011, 5'd7, 1, 0, 2'b00, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, $urandom, 5'($urandom), 1, $urandom_range(0, 1), 2'($urandom), 0, 1, 0);
      tick();
      chk("stall_data", write_data_out, 32'h0000_0011);
      chk("stall_reg", {27'd0, write_register_out}, 32'd7);
    end
    drive(1, 32'h0, 32'h0000_0022, 5'd8, 1, 0, 2'b00, 0, 1, 1);
    tick();
    chk("flush_rw", {31'd0, reg_write_out}, 32'd0);

    // Reset during a stall drops the held entry
    drive(1, 32'h0, 32'h0000_0033, 5'd3, 1, 0, 2'b00, 0, 0, 0);
    tick();
    stall = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_stall_rw", {31'd0, reg_write_out}, 32'd0);
    chk("rst_stall_data", write_data_out, 32'd0);
    stall = 1'b0;

    // Retire counter: 4 captures, stall, bubble, flush
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, $urandom, $urandom, 5'd1, 1, 0, 2'b00, 0, 0, 0);
      tick();
    end
    drive(1, 32'h0, 32'h0, 5'd1, 1, 0, 2'b00, 0, 1, 0); tick();
    drive(0, 32'h0, 32'h0, 5'd1, 1, 0, 2'b00, 0, 0, 0); tick();
    drive(1, 32'h0, 32'h0, 5'd1, 1, 0, 2'b00, 0, 0, 1); tick();
`ifdef RETIRE_CNT_EN
    chk("cnt_four", 32'(retired_count_out), 32'd4);
`endif
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(1, $urandom, $urandom, 5'd2, 1, 0, 2'b00, 0, 0, 0);
      tick();
    end
`ifdef RETIRE_CNT_EN
    chk("cnt_15", 32'(retired_count_out), 32'd15);
`endif
    tick();
`ifdef RETIRE_CNT_EN
    chk("cnt_wrap", 32'(retired_count_out), 32'd0);
`endif

    // Randomised traffic against the model
    drive(0, '0, '0, '0, 0, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom_range(0, 7)),
            $urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom), $urandom_range(0, 1),
            $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
      tick();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
